riscv_ras_stack: RTL and testbench

Storage/responder side of the return-address-stack (RAS) protocol. The RAS arbiter issues push/pop strobes with slot indices, and this block consumes them:
- a push writes the supplied return address into the indexed slot;
- a pop reads the indexed slot and returns a registered prediction to the fetch stage.
Also tracks occupancy, reports under/overflow, and supports a multi-cycle flush sweep that invalidates all slots.

---
 rtl/riscv_ras_stack.sv | 177 +++++++++++++++++
 tb/tb_riscv_ras_stack.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_ras_stack.sv
// Return-address-stack slot storage: indexed push/pop, occupancy, flush sweep.
// Ports: clk/reset(async high), enable, i_abort, i_flush, i_push/i_pop with
// slot addrs and push data; o_pop_* registered response, o_count/o_full/
// o_empty, o_underflow/o_overflow pulses, o_busy (sweep), o_parity_err.
// Optional macro RISCV_RAS_STACK_PARITY_EN: per-slot parity checked on pop.
module riscv_ras_stack #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int RAS_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          i_abort,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [ADDR_WIDTH-1:0]         i_push_addr,
  input  logic [ADDR_WIDTH-1:0]         i_pop_addr,
  input  logic [DATA_WIDTH-1:0]         i_push_data,
  output logic                          o_pop_valid,
  output logic                          o_pop_hit,
  output logic [DATA_WIDTH-1:0]         o_pop_data,
  output logic [$clog2(RAS_DEPTH):0]    o_count,
  output logic                          o_full,
  output logic                          o_empty,
  output logic                          o_underflow,
  output logic                          o_overflow,
  output logic                          o_busy,
  output logic                          o_parity_err
);

  localparam int IW = $clog2(RAS_DEPTH);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST  = IW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULLC = CW'(RAS_DEPTH);

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t state_q, state_d;
  logic [IW-1:0] sweep_q, sweep_d;

  logic [DATA_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [RAS_DEPTH-1:0]  vld_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [IW-1:0] pidx, qidx;
  logic idle, push_acc, pop_acc, resp;
  logic sweep_done;
  logic rd_vld, rd_err, rd_hit;
  logic [DATA_WIDTH-1:0] rd_data;

  logic pv_q, ph_q, uf_q, of_q, pe_q;
  logic [DATA_WIDTH-1:0] pd_q;

  logic unused_addr;
  assign unused_addr = ^{i_push_addr[ADDR_WIDTH-1:IW],
                         i_pop_addr[ADDR_WIDTH-1:IW]};

  assign pidx = i_push_addr[IW-1:0];
  assign qidx = i_pop_addr[IW-1:0];

  // A flush request closes the door in its own cycle.
  assign idle     = (state_q == S_IDLE) & ~i_flush;
  assign push_acc = i_push & enable & ~i_abort & idle;
  assign pop_acc  = i_pop & enable & idle;
  assign resp     = pop_acc & ~i_abort;

  assign sweep_done = (state_q == S_FLUSH) & (sweep_q == LAST);

  assign rd_data = mem_q[qidx];
  assign rd_vld  = vld_q[qidx];

`ifdef RISCV_RAS_STACK_PARITY_EN
  logic [RAS_DEPTH-1:0] par_q;

  assign rd_err = rd_vld & (par_q[qidx] != ^rd_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q <= '0;
    end else if (push_acc) begin
      par_q[pidx] <= ^i_push_data;
    end
  end
`else
  assign rd_err = 1'b0;
`endif

  assign rd_hit = rd_vld & ~rd_err;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_flush) begin
          state_d = S_FLUSH;
          sweep_d = '0;
        end
      end
      S_FLUSH: begin
        sweep_d = sweep_q + IW'(1);
        if (sweep_q == LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sweep_done)
      cnt_d = '0;
    else if (push_acc & ~pop_acc & (cnt_q != FULLC))
      cnt_d = cnt_q + CW'(1);
    else if (pop_acc & ~push_acc & (cnt_q != '0))
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sweep_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pop clear precedes push set so a same-slot push wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      if (state_q == S_FLUSH) vld_q[sweep_q] <= 1'b0;
      if (pop_acc) vld_q[qidx] <= 1'b0;
      if (push_acc) begin
        vld_q[pidx] <= 1'b1;
        mem_q[pidx] <= i_push_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv_q <= 1'b0;
      ph_q <= 1'b0;
      pd_q <= '0;
      pe_q <= 1'b0;
      uf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      pv_q <= resp;
      ph_q <= resp & rd_hit;
      pd_q <= (resp & rd_hit) ? rd_data : '0;
      pe_q <= resp & rd_err;
      uf_q <= pop_acc & ~push_acc & (cnt_q == '0);
      of_q <= push_acc & ~pop_acc & (cnt_q == FULLC);
    end
  end

  assign o_pop_valid  = pv_q;
  assign o_pop_hit    = ph_q;
  assign o_pop_data   = pd_q;
  assign o_parity_err = pe_q;
  assign o_underflow  = uf_q;
  assign o_overflow   = of_q;
  assign o_count      = cnt_q;
  assign o_full       = (cnt_q == FULLC);
  assign o_empty      = (cnt_q == '0);
  assign o_busy       = (state_q == S_FLUSH);

endmodule

// File: tb/tb_riscv_ras_stack.sv
// Bench for riscv_ras_stack: directed scenarios plus randomized traffic
// checked against a slot-array reference model.
module tb_riscv_ras_stack;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic reset, enable, i_abort, i_flush, i_push, i_pop;
  logic [AW-1:0] i_push_addr, i_pop_addr;
  logic [DW-1:0] i_push_data;
  logic o_pop_valid, o_pop_hit, o_full, o_empty;
  logic o_underflow, o_overflow, o_busy, o_parity_err;
  logic [DW-1:0] o_pop_data;
  logic [4:0] o_count;

  riscv_ras_stack #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAS_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .enable(enable), .i_abort(i_abort),
    .i_flush(i_flush), .i_push(i_push), .i_pop(i_pop),
    .i_push_addr(i_push_addr), .i_pop_addr(i_pop_addr),
    .i_push_data(i_push_data), .o_pop_valid(o_pop_valid),
    .o_pop_hit(o_pop_hit), .o_pop_data(o_pop_data), .o_count(o_count),
    .o_full(o_full), .o_empty(o_empty), .o_underflow(o_underflow),
    .o_overflow(o_overflow), .o_busy(o_busy), .o_parity_err(o_parity_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  bit mv[D];
  bit bad[D];
  logic [DW-1:0] md[D];
  int mcnt, mbusy;
  bit e_pv, e_ph, e_uf, e_of, e_pe;
  logic [DW-1:0] e_pd;

  wire [DW+12:0] act = {o_pop_valid, o_pop_hit, o_pop_data, o_count,
                        o_full, o_empty, o_underflow, o_overflow,
                        o_busy, o_parity_err};

  function automatic logic [DW+12:0] exp_vec();
    return {e_pv, e_ph, e_pd, 5'(mcnt), 1'(mcnt == D), 1'(mcnt == 0),
            e_uf, e_of, 1'(mbusy > 0), e_pe};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < D; k++) begin
      mv[k] = 0; bad[k] = 0; md[k] = '0;
    end
    mcnt = 0; mbusy = 0;
    e_pv = 0; e_ph = 0; e_uf = 0; e_of = 0; e_pe = 0; e_pd = '0;
  endtask

  task automatic idle_inputs();
    enable = 0; i_abort = 0; i_flush = 0; i_push = 0; i_pop = 0;
    i_push_addr = '0; i_pop_addr = '0; i_push_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; idle_inputs(); model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  // One clock of stimulus; model advances by the stack's rules.
  task automatic drive(bit pu, bit po, logic [AW-1:0] pa,
                       logic [AW-1:0] qa, logic [DW-1:0] d,
                       bit ab, bit fl, bit en);
    int pi, qi;
    bit ok, pacc, qacc;
    @(negedge clk);
    i_push = pu; i_pop = po; i_push_addr = pa; i_pop_addr = qa;
    i_push_data = d; i_abort = ab; i_flush = fl; enable = en;
    pi = int'(pa % D);
    qi = int'(qa % D);
    ok = (mbusy == 0) && !fl;
    pacc = pu && en && !ab && ok;
    qacc = po && en && ok;
    e_pv = qacc && !ab;
    e_pe = e_pv && mv[qi] && bad[qi];
    e_ph = e_pv && mv[qi] && !bad[qi];
    e_pd = e_ph ? md[qi] : '0;
    e_uf = qacc && !pacc && mcnt == 0;
    e_of = pacc && !qacc && mcnt == D;
    if (qacc) mv[qi] = 0;
    if (pacc) begin mv[pi] = 1; md[pi] = d; bad[pi] = 0; end
    if (pacc && !qacc && mcnt < D) mcnt++;
    if (qacc && !pacc && mcnt > 0) mcnt--;
    if (mbusy > 0) begin
      mbusy--;
      if (mbusy == 0) mcnt = 0;
    end else if (fl) begin
      mbusy = D;
      for (int k = 0; k < D; k++) mv[k] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(int idx, logic [DW-1:0] d);
    drive(1, 0, AW'(idx), '0, d, 0, 0, 1);
  endtask

  task automatic pop(int idx);
    drive(0, 1, '0, AW'(idx), '0, 0, 0, 1);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; idle_inputs(); model_clear();
    @(posedge clk); #1;
    n_cmp++;
    if (act !== (DW+13)'(16)) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", act, (DW+13)'(16));
    end
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    n_cmp++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_release: empty %b count %0d want 1/0",
               o_empty, o_count);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    push(3, 64'h8000_0010);
    n_cmp++;
    if (o_count !== 5'd1 || o_pop_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL push_count: count %0d pv %b want 1/0",
               o_count, o_pop_valid);
    end
    pop(3);
    n_cmp++;
    if ({o_pop_valid, o_pop_hit, o_pop_data, o_count} !==
        {1'b1, 1'b1, 64'h8000_0010, 5'd0}) begin
      n_bad++;
      $display("FAIL pop_hit: pv %b hit %b data %h count %0d want 1/1/80000010/0",
               o_pop_valid, o_pop_hit, o_pop_data, o_count);
    end
    drive(0, 0, '0, '0, '0, 0, 0, 1);
    n_cmp++;
    if (o_pop_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pop_pulse: pv %b want 0", o_pop_valid);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    pop(0);
    n_cmp++;
    if ({o_underflow, o_pop_valid, o_pop_hit, o_pop_data, o_count} !==
        {1'b1, 1'b1, 1'b0, 64'h0, 5'd0}) begin
      n_bad++;
      $display("FAIL underflow: uf %b pv %b hit %b data %h count %0d want 1/1/0/0/0",
               o_underflow, o_pop_valid, o_pop_hit, o_pop_data, o_count);
    end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] hi;
    do_reset();
    for (int i = 0; i < D; i++) begin
      hi = {$urandom, $urandom};
      drive(1, 0, (hi << 4) | AW'(i), '0, DW'(32'h100 + i), 0, 0, 1);
    end
    n_cmp++;
    if (o_full !== 1'b1 || o_count !== 5'd16 || o_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL fill: full %b count %0d of %b want 1/16/0",
               o_full, o_count, o_overflow);
    end
    push(0, 64'hAAA);
    n_cmp++;
    if (o_overflow !== 1'b1 || o_count !== 5'd16) begin
      n_bad++;
      $display("FAIL overflow: of %b count %0d want 1/16",
               o_overflow, o_count);
    end
    pop(0);
    n_cmp++;
    if (o_pop_data !== 64'hAAA || o_pop_hit !== 1'b1 ||
        o_overflow !== 1'b0 || o_count !== 5'd15) begin
      n_bad++;
      $display("FAIL overwrite_pop: data %h hit %b of %b count %0d want aaa/1/0/15",
               o_pop_data, o_pop_hit, o_overflow, o_count);
    end
  endtask

  task automatic test_same_idx();
    do_reset();
    drive(1, 1, AW'(5), AW'(5), 64'h40, 0, 0, 1);
    n_cmp++;
    if ({o_pop_valid, o_pop_hit, o_pop_data, o_count} !==
        {1'b1, 1'b0, 64'h0, 5'd0}) begin
      n_bad++;
      $display("FAIL rbw: pv %b hit %b data %h count %0d want 1/0/0/0",
               o_pop_valid, o_pop_hit, o_pop_data, o_count);
    end
    pop(5);
    n_cmp++;
    if (o_pop_hit !== 1'b1 || o_pop_data !== 64'h40) begin
      n_bad++;
      $display("FAIL push_wins: hit %b data %h want 1/40",
               o_pop_hit, o_pop_data);
    end
  endtask

  task automatic test_abort();
    do_reset();
    push(2, 64'h22);
    drive(0, 1, '0, AW'(2), '0, 1, 0, 1);
    n_cmp++;
    if (o_pop_valid !== 1'b0 || o_count !== 5'd0) begin
      n_bad++;
      $display("FAIL abort_pop: pv %b count %0d want 0/0",
               o_pop_valid, o_count);
    end
    drive(1, 0, AW'(7), '0, 64'h77, 1, 0, 1);
    n_cmp++;
    if (o_count !== 5'd0) begin
      n_bad++;
      $display("FAIL abort_push: count %0d want 0", o_count);
    end
    drive(1, 0, AW'(9), '0, 64'h99, 0, 0, 0);
    n_cmp++;
    if (o_count !== 5'd0) begin
      n_bad++;
      $display("FAIL disabled_push: count %0d want 0", o_count);
    end
    pop(7);
    n_cmp++;
    if (o_pop_valid !== 1'b1 || o_pop_hit !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_slot: pv %b hit %b want 1/0",
               o_pop_valid, o_pop_hit);
    end
  endtask

  task automatic test_flush();
    int cycles;
    do_reset();
    for (int i = 1; i <= 4; i++) push(i, DW'(i * 3));
    drive(0, 1, '0, AW'(1), '0, 0, 1, 1);
    n_cmp++;
    if (o_pop_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_start: pv %b busy %b want 0/1",
               o_pop_valid, o_busy);
    end
    cycles = 0;
    for (int g = 0; g < 40 && o_busy; g++) begin
      cycles++;
      drive(1, 1, AW'($urandom), AW'($urandom), DW'($urandom),
            1'($urandom), 1'($urandom), 1);
      n_cmp++;
      if (act !== exp_vec()) begin
        n_bad++;
        $display("FAIL sweep_cycle: got %h want %h", act, exp_vec());
      end
    end
    n_cmp++;
    if (cycles != 16 || o_count !== 5'd0 || o_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL sweep_len: busy %0d count %0d empty %b want 16/0/1",
               cycles, o_count, o_empty);
    end
    for (int i = 0; i < D; i++) begin
      pop(i);
      n_cmp++;
      if (o_pop_hit !== 1'b0 || o_pop_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL post_flush_pop%0d: pv %b hit %b want 1/0",
                 i, o_pop_valid, o_pop_hit);
      end
    end
    push(6, 64'h66);
    drive(0, 0, '0, '0, '0, 0, 1, 1);
    repeat (5) drive(0, 0, '0, '0, '0, 0, 0, 1);
    @(negedge clk);
    reset = 1;
    #1;
    n_cmp++;
    if (o_busy !== 1'b0 || o_count !== 5'd0 || o_empty !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_flush: busy %b count %0d empty %b want 0/0/1",
               o_busy, o_count, o_empty);
    end
    idle_inputs(); model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_random();
    bit pu, po, ab, fl, en;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      ab = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 7) != 0);
      drive(pu, po, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, ab, fl, en);
      n_cmp++;
      if (act !== exp_vec()) begin
        n_bad++;
        $display("FAIL random_%0d: got %h want %h", n, act, exp_vec());
      end
    end
  endtask

`ifdef RISCV_RAS_STACK_PARITY_EN
  task automatic test_parity();
    do_reset();
    push(6, 64'h1234);
    @(negedge clk);
    dut.par_q[6] = ~dut.par_q[6];
    bad[6] = 1;
    pop(6);
    n_cmp++;
    if ({o_pop_valid, o_pop_hit, o_parity_err} !== 3'b101) begin
      n_bad++;
      $display("FAIL parity: pv %b hit %b perr %b want 1/0/1",
               o_pop_valid, o_pop_hit, o_parity_err);
    end
  endtask
`endif

  initial begin
    reset = 1;
    idle_inputs();
    model_clear();
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_same_idx();
    test_abort();
    test_flush();
    test_random();
`ifdef RISCV_RAS_STACK_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
